fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Read-side controller for sync_fifo_32x8. It drains the FIFO's read port (rd_en/dout/empty) and presents the words on a valid/ready output stream with no loss or duplication. It absorbs the FIFO's one-cycle registered read latency in a small internal buffer and tags fixed-length bursts with a last marker. It sits between the FIFO and downstream consumers such as a serializer or DMA sink.

Parameters:
WIDTH, 8, data word width; must match the FIFO.
BUF_DEPTH, 4, entries in the internal output buffer; minimum 3 for full throughput; power of two.
BURST_LEN, 8, accepted beats per burst; m_last marks the final beat.
CNT_W, 16, width of word_cnt.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  permits new FIFO reads when 1
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  WIDTH  FIFO read data, valid the cycle after a sampled rd_en
fifo_rd_en  out  1  read strobe to FIFO
m_valid  out  1  output word available
m_ready  in  1  consumer accepts word
m_data  out  WIDTH  output word
m_last  out  1  final beat of current burst
word_cnt  out  CNT_W  total accepted beats, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate): fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, word_cnt=0. Buffer occupancy (occ), rd_pending and beat counter are cleared. Any in-flight read is discarded.
- fifo_rd_en = enable && !fifo_empty && (occ + rd_pending) < BUF_DEPTH. It is registered-state-only, with no combinational path from m_ready.
- rd_pending <= fifo_rd_en each cycle. When rd_pending=1, fifo_dout is written into the buffer tail at the next edge.
- Latency: fifo_rd_en high in cycle N, buffer capture at edge N+2, m_valid high from edge N+2 when the buffer was empty. Two cycles from strobe to valid.
- Throughput: with BUF_DEPTH>=3, m_ready=1 and a non-empty FIFO, the block sustains one beat per cycle after the initial latency.
- m_data is the buffer head and m_valid = (occ != 0). Once m_valid is asserted, it and m_data stay stable until m_valid && m_ready.
- Handshake (m_valid && m_ready) pops the head and increments word_cnt. Capture and pop in the same cycle leave occ unchanged.
- Burst tagging: the beat counter runs 0..BURST_LEN-1 and increments on handshake. m_last = m_valid && (beat == BURST_LEN-1), and the counter wraps to 0 after the last beat.
- Overflow is impossible by construction: occ + rd_pending never exceeds BUF_DEPTH.
- Underflow: fifo_rd_en is never asserted while fifo_empty=1.
- enable=0 blocks new reads only. A pending capture still completes, and buffered words still drain to the consumer.
- Data order is strictly FIFO order.
- Circular buffer pointers wrap modulo BUF_DEPTH.

Decomposition:
- Package fifo_rd_pkg: default WIDTH/BUF_DEPTH/BURST_LEN/CNT_W constants and the derived pointer width (clog2 BUF_DEPTH) and occ width.
- One sub-module, fifo_rd_outbuf: a BUF_DEPTH-entry circular register buffer with push/pop, occ, head data and async reset.
- Top-level logic: read-issue logic, rd_pending, beat counter and word_cnt.

Test Plan:
- Reset: hold rst=1 with FIFO non-empty -> fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, word_cnt=0; assert rst mid-cycle -> outputs clear without waiting for a clock.
- Single word: write 0x7C to FIFO, enable=1, m_ready=1 -> one fifo_rd_en pulse; m_valid 2 cycles later with m_data=0x7C; word_cnt=1; m_last=0.
- Stream: fill FIFO with 0..31 (full), m_ready=1 -> after latency 32 consecutive beats with data 0..31 in order; m_last on data 7, 15, 23, 31; fifo_rd_en never high while fifo_empty; word_cnt=32.
- Backpressure: 10 words queued, m_ready=0 -> exactly 4 reads issued, m_valid held, m_data=first word stable; then m_ready=1 -> remaining 10 delivered in order, no loss or duplication.
- Enable/underflow: enable=0 with 5 words queued -> zero reads. Empty FIFO with enable=1 for 20 cycles -> fifo_rd_en=0 and m_valid=0 throughout.
- Reset mid-stream: rst asserted with 2 buffered words and 1 pending read -> all cleared. After release, delivery resumes at the FIFO's current head; m_last on the 8th post-reset beat; word_cnt restarts at 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared constants for the FIFO read-side stream controller.
// Defaults match sync_fifo_32x8; widths are derived from the buffer depth.
package fifo_rd_pkg;

    localparam int WIDTH_D     = 8;
    localparam int BUF_DEPTH_D = 4;
    localparam int BURST_LEN_D = 8;
    localparam int CNT_W_D     = 16;

    localparam int PTR_W_D = $clog2(BUF_DEPTH_D);
    localparam int OCC_W_D = $clog2(BUF_DEPTH_D + 1);

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int beat_w(input int burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream.
// master = the reader, slave = FIFO and consumer side.
interface fifo_stream_reader_if
    import fifo_rd_pkg::*;
    #(parameter int WIDTH = WIDTH_D);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/fifo_rd_outbuf.sv
// Circular register buffer that absorbs the FIFO read latency.
// Head entry is presented combinationally; pop is ignored when empty.
module fifo_rd_outbuf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int DEPTH = BUF_DEPTH_D
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_wdata,
    input  logic                        i_pop,
    output logic [$clog2(DEPTH+1)-1:0]  o_occ,
    output logic [WIDTH-1:0]            o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_pop;

    assign w_pop  = i_pop && (r_occ != '0);
    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            unique case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains sync_fifo_32x8 onto a valid/ready stream with burst last tagging.
// Reads are issued only against guaranteed buffer space, so no m_ready path.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH     = WIDTH_D,
    parameter int BUF_DEPTH = BUF_DEPTH_D,
    parameter int BURST_LEN = BURST_LEN_D,
    parameter int CNT_W     = CNT_W_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic [CNT_W-1:0]     word_cnt
);

    localparam int OCC_W  = occ_w(BUF_DEPTH);
    localparam int BEAT_W = beat_w(BURST_LEN);

    logic              r_rd_pending;
    logic [BEAT_W-1:0] r_beat;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [OCC_W-1:0]  w_occ;
    logic [OCC_W:0]    w_inflight;
    logic              w_hs;
    logic              w_beat_end;

    // Words already buffered plus the one still in the FIFO pipeline.
    assign w_inflight = {1'b0, w_occ} + (OCC_W+1)'(r_rd_pending);

    assign bus.fifo_rd_en = !rst && enable && !bus.fifo_empty
                         && (w_inflight < (OCC_W+1)'(BUF_DEPTH));

    assign bus.m_valid = (w_occ != '0);
    assign w_hs        = bus.m_valid && bus.m_ready;
    assign w_beat_end  = (r_beat == BEAT_W'(BURST_LEN - 1));
    assign bus.m_last  = bus.m_valid && w_beat_end;
    assign word_cnt    = r_word_cnt;

    fifo_rd_outbuf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_outbuf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_pending),
        .i_wdata (bus.fifo_dout),
        .i_pop   (w_hs),
        .o_occ   (w_occ),
        .o_head  (bus.m_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pending <= 1'b0;
            r_beat       <= '0;
            r_word_cnt   <= '0;
        end else begin
            r_rd_pending <= bus.fifo_rd_en;
            if (w_hs) begin
                r_beat     <= w_beat_end ? '0 : r_beat + BEAT_W'(1);
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, stream scoreboard,
// table-driven scenarios and hand-written latency/reset sequences.
module tb_fifo_stream_reader;
    import fifo_rd_pkg::*;

    localparam int W  = 8;
    localparam int BD = 4;
    localparam int BL = 8;
    localparam int CW = 16;
    localparam int AW = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] word_cnt;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.WIDTH(W)) bus ();

    fifo_stream_reader #(
        .WIDTH     (W),
        .BUF_DEPTH (BD),
        .BURST_LEN (BL),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus),
        .word_cnt (word_cnt)
    );

    // FIFO model with one-cycle registered read data
    logic [W-1:0] fmem [AW];
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit flush  = 1'b0;

    assign bus.fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (flush) begin
            rd_cnt <= wr_cnt;
        end else if (bus.fifo_rd_en && (wr_cnt != rd_cnt)) begin
            bus.fifo_dout <= fmem[rd_cnt % AW];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    // Stream monitor and scoreboard, sampled mid-cycle
    int beats = 0, lasts = 0, rd_pulses = 0, valid_cyc = 0;
    int data_err = 0, last_err = 0, uf_err = 0, stab_err = 0;
    int exp_idx = 0, beat_idx = 0;
    bit prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            beat_idx  = 0;
            exp_idx   = rd_cnt;
            prev_hold = 1'b0;
        end else begin
            if (bus.fifo_rd_en) rd_pulses++;
            if (bus.fifo_rd_en && bus.fifo_empty) uf_err++;
            if (bus.m_valid) valid_cyc++;
            if (prev_hold && (!bus.m_valid || bus.m_data != prev_data))
                stab_err++;
            if (bus.m_last != (bus.m_valid && (beat_idx % BL == BL - 1)))
                last_err++;
            if (bus.m_valid && bus.m_ready) begin
                beats++;
                if (bus.m_last) lasts++;
                if (bus.m_data != fmem[exp_idx % AW]) data_err++;
                exp_idx++;
                beat_idx++;
            end
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        fmem[wr_cnt % AW] = d;
        wr_cnt++;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b1;
        cyc(2);
        flush = 1'b0;
        rst   = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] base;
        int           npush;
        bit           en;
        bit           rdy;
        int           ncyc;
        int           exp_rd;
        int           exp_beats;
        int           exp_lasts;
        int           exp_valid;
        int           exp_vcyc;
    } vec_t;

    vec_t vecs[5];

    int s_rd, s_beats, s_lasts, s_vcyc, s_derr, s_lerr, s_uf, s_stab;

    task automatic snap();
        s_rd    = rd_pulses;
        s_beats = beats;
        s_lasts = lasts;
        s_vcyc  = valid_cyc;
        s_derr  = data_err;
        s_lerr  = last_err;
        s_uf    = uf_err;
        s_stab  = stab_err;
    endtask

    initial begin
        vecs[0] = '{8'h7C, 1,  1'b1, 1'b1, 10, 1,  1,  0, 0, 1};
        vecs[1] = '{8'h00, 32, 1'b1, 1'b1, 36, 32, 32, 4, 0, 32};
        vecs[2] = '{8'h40, 10, 1'b1, 1'b0, 12, 4,  0,  0, 1, 10};
        vecs[3] = '{8'h60, 5,  1'b0, 1'b1, 12, 0,  0,  0, 0, 0};
        vecs[4] = '{8'h00, 0,  1'b1, 1'b1, 20, 0,  0,  0, 0, 0};

        bus.m_ready = 1'b1;
        enable      = 1'b1;

        // Reset held while the FIFO has data
        for (int i = 0; i < 3; i++) push(W'(8'h11 + i));
        cyc(3);
        chk("rst_rd_en",  int'(bus.fifo_rd_en), 0);
        chk("rst_valid",  int'(bus.m_valid), 0);
        chk("rst_data",   int'(bus.m_data), 0);
        chk("rst_last",   int'(bus.m_last), 0);
        chk("rst_wcnt",   int'(word_cnt), 0);
        do_reset();

        for (int v = 0; v < 5; v++) begin
            do_reset();
            enable      = vecs[v].en;
            bus.m_ready = vecs[v].rdy;
            snap();
            for (int i = 0; i < vecs[v].npush; i++)
                push(vecs[v].base + W'(i));
            cyc(vecs[v].ncyc);
            chk($sformatf("v%0d_reads", v), rd_pulses - s_rd, vecs[v].exp_rd);
            chk($sformatf("v%0d_beats", v), beats - s_beats, vecs[v].exp_beats);
            chk($sformatf("v%0d_lasts", v), lasts - s_lasts, vecs[v].exp_lasts);
            chk($sformatf("v%0d_valid", v), int'(bus.m_valid), vecs[v].exp_valid);
            chk($sformatf("v%0d_vcyc", v), valid_cyc - s_vcyc, vecs[v].exp_vcyc);
            chk($sformatf("v%0d_wcnt", v), int'(word_cnt), vecs[v].exp_beats);
            chk($sformatf("v%0d_data", v), data_err - s_derr, 0);
            chk($sformatf("v%0d_last", v), last_err - s_lerr, 0);
            chk($sformatf("v%0d_underflow", v), uf_err - s_uf, 0);
            chk($sformatf("v%0d_stable", v), stab_err - s_stab, 0);
        end

        // Exact strobe-to-valid latency
        do_reset();
        enable      = 1'b1;
        bus.m_ready = 1'b0;
        push(8'h7C);
        #1;
        chk("lat_c0_rd", int'(bus.fifo_rd_en), 1);
        chk("lat_c0_valid", int'(bus.m_valid), 0);
        cyc(1);
        chk("lat_c1_rd", int'(bus.fifo_rd_en), 0);
        chk("lat_c1_valid", int'(bus.m_valid), 0);
        cyc(1);
        chk("lat_c2_valid", int'(bus.m_valid), 1);
        chk("lat_c2_data", int'(bus.m_data), 8'h7C);
        chk("lat_c2_last", int'(bus.m_last), 0);
        bus.m_ready = 1'b1;
        cyc(1);
        chk("lat_pop_valid", int'(bus.m_valid), 0);
        chk("lat_wcnt", int'(word_cnt), 1);

        // Backpressure then release
        do_reset();
        bus.m_ready = 1'b0;
        snap();
        for (int i = 0; i < 10; i++) push(W'(8'h80 + i));
        cyc(12);
        chk("bp_reads", rd_pulses - s_rd, 4);
        chk("bp_valid", int'(bus.m_valid), 1);
        chk("bp_head", int'(bus.m_data), 8'h80);
        bus.m_ready = 1'b1;
        cyc(20);
        chk("bp_beats", beats - s_beats, 10);
        chk("bp_data", data_err - s_derr, 0);
        chk("bp_stable", stab_err - s_stab, 0);
        chk("bp_wcnt", int'(word_cnt), 10);
        chk("bp_drained", int'(bus.fifo_empty), 1);

        // Async reset with two buffered words and one read in flight
        bus.m_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(W'(8'hA0 + i));
        cyc(3);
        chk("ms_pre_valid", int'(bus.m_valid), 1);
        chk("ms_pre_data", int'(bus.m_data), 8'hA0);
        chk("ms_pre_rd", int'(bus.fifo_rd_en), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ms_async_valid", int'(bus.m_valid), 0);
        chk("ms_async_data", int'(bus.m_data), 0);
        chk("ms_async_rd", int'(bus.fifo_rd_en), 0);
        chk("ms_async_wcnt", int'(word_cnt), 0);
        chk("ms_async_last", int'(bus.m_last), 0);
        cyc(2);
        chk("ms_fifo_head", rd_cnt, wr_cnt - 9);
        snap();
        rst         = 1'b0;
        bus.m_ready = 1'b1;
        cyc(20);
        chk("ms_beats", beats - s_beats, 9);
        chk("ms_data", data_err - s_derr, 0);
        chk("ms_lasts", lasts - s_lasts, 1);
        chk("ms_last", last_err - s_lerr, 0);
        chk("ms_wcnt", int'(word_cnt), 9);
        chk("all_underflow", uf_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
